simon_round_ctrl: RTL
=====================

Name: simon_round_ctrl

Overview:
Round sequencer for the colour-memory game. It grows a random colour pattern by one entry per round and plays the pattern on the colour display using tick-based timing. It then collects and checks the player's button presses against the pattern, keeps the score, and drives the buzzer on failure. It sits between the slow-tick divider, the random source, the button decoder and the LED/display driver.

Parameters:
MAX_LEN, 16, pattern capacity (entries); length counter width LW = clog2(MAX_LEN+1)
COLOR_BITS, 2, colour code width (0 red, 1 green, 2 blue, 3 yellow)
SHOW_TICKS, 20, ticks each pattern colour is displayed
GAP_TICKS, 5, ticks of blank display between colours
INPUT_TICKS, 50, ticks allowed per player press before timeout
BUZZ_TICKS, 30, ticks buzzer stays on after failure

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-clk enable strobe from slow divider (~16 ms)
start  in  1  begin new game (level-sampled)
rnd  in  COLOR_BITS  random colour, sampled in APPEND
btn_valid  in  1  one-clk strobe, player pressed a button
btn_color  in  COLOR_BITS  colour of press, valid with btn_valid
disp_color  out  COLOR_BITS+1  colour to display; MSB=1 means off (NULL = 3'b100)
score  out  8  completed rounds, saturates at 255
level  out  LW  current pattern length
busy  out  1  high in every state except IDLE and OVER
game_over  out  1  high in OVER
buzzer  out  1  high in FAIL

Behaviour:
- All outputs registered; they update on the same clk edge as the state. Timers advance only on clk edges with tick=1.
- Reset values: state IDLE, disp_color=NULL, score=0, level=0, busy=0, game_over=0, buzzer=0, timer=0, idx=0. Pattern RAM contents are don't-care.
- Reset asserted mid-operation returns to IDLE on the next edge. Reset overrides every other input.
- States: IDLE, APPEND, SHOW, GAP, WAIT_IN, FAIL, OVER, WIN.
- IDLE: on start=1, go to APPEND; score<=0, level<=0.
- APPEND (1 clk): pattern[level]<=rnd; level<=level+1; idx<=0; timer<=0; go to SHOW.
- SHOW: disp_color={0,pattern[idx]}. On a tick with timer==SHOW_TICKS-1, go to GAP and clear timer; on other ticks, timer++.
- GAP: disp_color=NULL. On a tick with timer==GAP_TICKS-1:
  - if idx==level-1, go to WAIT_IN with idx=0;
  - otherwise idx++ and go to SHOW.
  - Timer cleared on either exit.
- WAIT_IN: disp_color=NULL. When btn_valid=1:
  - mismatch (btn_color!=pattern[idx]): go to FAIL.
  - match with idx<level-1: idx++, timer<=0.
  - match with idx==level-1: score<=score+1 (saturating). If level==MAX_LEN go to WIN, else go to APPEND.
- WAIT_IN, no press: on a tick with timer==INPUT_TICKS-1, go to FAIL (timeout). btn_valid and tick in the same cycle: the press is processed and the tick is ignored.
- FAIL: buzzer=1. On a tick with timer==BUZZ_TICKS-1, go to OVER.
- OVER / WIN: game_over=1 in OVER; WIN holds disp_color=NULL with game_over=0. On start=1, both go to APPEND with score<=0, level<=0. score and level hold their values until then.
- btn_valid is ignored outside WAIT_IN. start is ignored outside IDLE, OVER and WIN.
- SHOW lasts exactly SHOW_TICKS ticks; GAP lasts exactly GAP_TICKS ticks; no off-by-one.
- Pattern storage is an internal MAX_LEN x COLOR_BITS register array, written only in APPEND.

Test Plan:
Common bench settings: MAX_LEN=3, SHOW_TICKS=2, GAP_TICKS=1, INPUT_TICKS=3, BUZZ_TICKS=2, tick every 4 clks.
- Reset then idle: hold start=0 for 50 clks -> disp_color=3'b100, score=0, level=0, busy=0, game_over=0, buzzer=0.
- Round 1 playback: start=1 with rnd=2 -> level=1. disp_color=3'b010 for exactly 2 ticks, then NULL for 1 tick, then WAIT_IN.
- Correct entry: in WAIT_IN press btn_color=2 -> score=1, level=2. Replay shows pattern[0]=2 then the new rnd=1 (3'b010, NULL, 3'b001, NULL).
- Wrong press: round 2 with pattern {2,1}, press 2 then 3 -> FAIL, buzzer=1 for exactly 2 ticks, then game_over=1 with score=1 held.
- Timeout and tie: in WAIT_IN, no press for 3 ticks -> FAIL. Separately, a correct press coincident with the 3rd tick -> accepted, no FAIL.
- Win, restart and reset: complete 3 rounds -> score=3, state WIN, game_over=0; start -> score=0, level=1. Reset asserted during SHOW -> next edge all outputs at reset values.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Round sequencer for the colour-memory game: grows the random pattern, plays it back
// on the display with tick-based timing, checks the player's presses and keeps score.
module simon_round_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int COLOR_BITS  = 2,
    parameter int SHOW_TICKS  = 20,
    parameter int GAP_TICKS   = 5,
    parameter int INPUT_TICKS = 50,
    parameter int BUZZ_TICKS  = 30,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic [COLOR_BITS-1:0] rnd,
    input  logic                  btn_valid,
    input  logic [COLOR_BITS-1:0] btn_color,
    output logic [COLOR_BITS:0]   disp_color,
    output logic [7:0]            score,
    output logic [LW-1:0]         level,
    output logic                  busy,
    output logic                  game_over,
    output logic                  buzzer
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int T1   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int T2   = (INPUT_TICKS > BUZZ_TICKS) ? INPUT_TICKS : BUZZ_TICKS;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [COLOR_BITS:0] NULL_COLOR = {1'b1, {COLOR_BITS{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, APPEND, SHOW, GAP, WAIT_IN, FAIL, OVER, WIN
    } state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [LW-1:0]         idx, idx_n, level_n;
    logic [7:0]            score_n;
    logic                  wr_en;
    logic                  last_idx;
    logic                  press_match;
    logic [COLOR_BITS-1:0] show_color;
    logic [COLOR_BITS:0]   disp_n;
    logic [COLOR_BITS-1:0] pattern [MAX_LEN];

    assign last_idx    = (idx == level - LW'(1));
    assign press_match = (btn_color == pattern[idx[AW-1:0]]);

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        level_n = level;
        score_n = score;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = APPEND;
                    score_n = 8'd0;
                    level_n = '0;
                end
            end
            APPEND: begin
                wr_en   = 1'b1;
                level_n = level + LW'(1);
                idx_n   = '0;
                timer_n = '0;
                state_n = SHOW;
            end
            SHOW: begin
                if (tick) begin
                    if (timer == TW'(SHOW_TICKS - 1)) begin
                        state_n = GAP;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (timer == TW'(GAP_TICKS - 1)) begin
                        timer_n = '0;
                        if (last_idx) begin
                            state_n = WAIT_IN;
                            idx_n   = '0;
                        end else begin
                            state_n = SHOW;
                            idx_n   = idx + LW'(1);
                        end
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            WAIT_IN: begin
                // A press wins over a coincident tick, so a last-moment press is never timed out.
                if (btn_valid) begin
                    if (!press_match) begin
                        state_n = FAIL;
                        timer_n = '0;
                    end else if (!last_idx) begin
                        idx_n   = idx + LW'(1);
                        timer_n = '0;
                    end else begin
                        score_n = (score == 8'hFF) ? score : score + 8'd1;
                        state_n = (level == LW'(MAX_LEN)) ? WIN : APPEND;
                    end
                end else if (tick) begin
                    if (timer == TW'(INPUT_TICKS - 1)) begin
                        state_n = FAIL;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            FAIL: begin
                if (tick) begin
                    if (timer == TW'(BUZZ_TICKS - 1)) begin
                        state_n = OVER;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            OVER, WIN: begin
                if (start) begin
                    state_n = APPEND;
                    score_n = 8'd0;
                    level_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Entering SHOW from APPEND may display the entry being written on that same edge.
    always_comb begin
        show_color = pattern[idx_n[AW-1:0]];
        if (wr_en && (level[AW-1:0] == idx_n[AW-1:0])) begin
            show_color = rnd;
        end
        disp_n = (state_n == SHOW) ? {1'b0, show_color} : NULL_COLOR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            level      <= '0;
            score      <= 8'd0;
            disp_color <= NULL_COLOR;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            level      <= level_n;
            score      <= score_n;
            disp_color <= disp_n;
            busy       <= (state_n != IDLE) && (state_n != OVER);
            game_over  <= (state_n == OVER);
            buzzer     <= (state_n == FAIL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pattern[level[AW-1:0]] <= rnd;
        end
    end

endmodule
